conv_result_writer: RTL and testbench
=====================================

Name: conv_result_writer

Overview:
- Sink end of the convolution output stream: captures the convolutor's valid/data beats into an internal result memory of OUT_DIM x OUT_DIM words, with OUT_DIM = N-K_SIZE+1.
- Scales and saturates each beat, tracks row/column position, and signals frame completion.
- Exposes a registered random-access readback port for host or downstream logic.
- Sits after the convolution top, mirroring the image-block reader on the input side.

Parameters:
- N, 4, input image side length.
- K_SIZE, 3, kernel side length; OUT_DIM = N-K_SIZE+1, OUT_PIX = OUT_DIM*OUT_DIM (localparams).
- IN_WIDTH, 16, width of incoming signed data_i.
- DATA_WIDTH, 16, width of stored signed result word.
- SHIFT, 0, arithmetic right shift applied before saturation.
- ADDR_WIDTH, 14, width of wr/rd address counters; must satisfy 2^ADDR_WIDTH >= OUT_PIX.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  arm/re-arm capture of a new frame.
- valid_i  in  1  data_i beat valid (no backpressure; every beat must be taken or flagged).
- data_i  in  IN_WIDTH  signed convolution result.
- busy_o  out  1  high while in CAPTURE.
- done_o  out  1  one-cycle pulse when the last of OUT_PIX beats is written.
- drop_o  out  1  sticky: a valid_i beat arrived outside CAPTURE.
- wr_row_o  out  ADDR_WIDTH  row index of the next write.
- wr_col_o  out  ADDR_WIDTH  column index of the next write.
- rd_en_i  in  1  read request.
- rd_addr_i  in  ADDR_WIDTH  linear read address (row*OUT_DIM+col).
- rd_data_o  out  DATA_WIDTH  read data, registered.
- rd_valid_o  out  1  rd_data_o valid, one cycle after rd_en_i.

Behaviour:
- Reset: state IDLE; wr_ptr, wr_row_o, wr_col_o = 0; busy_o, done_o, drop_o, rd_valid_o = 0; rd_data_o = 0. Memory contents are not cleared.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE/DONE + start_i -> CAPTURE; pointers cleared to 0, drop_o cleared.
  - CAPTURE + start_i -> stays CAPTURE and aborts: pointers reset to 0; a valid_i in the same cycle is written at address 0.
  - CAPTURE + valid_i writes mem[wr_ptr]; wr_ptr increments; wr_col_o increments, wrapping to 0 at OUT_DIM with wr_row_o++.
  - Write of beat OUT_PIX-1 -> DONE next cycle; done_o=1 for exactly that one cycle; wr_row_o/wr_col_o return to 0.
- valid_i in IDLE or DONE (start_i low): beat discarded, memory unchanged, drop_o set and held until the next start_i or rst.
- Arithmetic: t = data_i >>> SHIFT (sign-preserving); if t > 2^(DATA_WIDTH-1)-1 store max positive; if t < -2^(DATA_WIDTH-1) store min negative; else store the low DATA_WIDTH bits. This is combinational ahead of the write, so write latency is 0 cycles (beat in cycle c is readable from cycle c+1).
- Readback: rd_en_i in cycle c -> rd_data_o and rd_valid_o=1 in cycle c+1; rd_valid_o=0 otherwise, and rd_data_o holds its last value.
  - Same-cycle read and write to one address returns old data (read-first).
  - rd_addr_i >= OUT_PIX returns 0 with rd_valid_o=1.
  - Reads are allowed in any state.
- rst mid-capture: immediate return to IDLE at the next edge; a partial frame stays in memory, and done_o is not pulsed.

Test Plan:
- N=4,K=3 (OUT_PIX=4): start_i, then valid_i with 10,20,30,40 on consecutive cycles -> done_o pulses one cycle after the 40 beat; read addr 0..3 returns 10,20,30,40, each one cycle after rd_en_i; wr_row/col sequence (0,0),(0,1),(1,0),(1,1),(0,0).
- Gapped valid (beats at cycles 0,3,4,9) -> same contents; busy_o high throughout; done_o only after the 4th beat.
- IN_WIDTH=24, DATA_WIDTH=16, SHIFT=4: inputs 0x100000, 0xF00000, 0x000123, 0xFFFFF0 -> stored 0x7FFF, 0x8000, 0x0012, 0xFFFF.
- valid_i=1 with data 99 in DONE -> drop_o=1 and memory unchanged; next start_i clears drop_o; the new frame overwrites.
- Abort: start_i after 2 beats, then 4 beats of 5,6,7,8 -> mem = 5,6,7,8 and a single done_o pulse. Separately, rst after 2 beats -> busy_o=0, no done_o, and previously written words remain readable.
- Read at addr 4 (out of range) -> rd_data_o=0, rd_valid_o=1. Same-cycle read/write to addr 1 -> old value returned.

Source files
------------

// File: rtl/conv_result_writer_if.sv
// ----------------------------------------------------------------------------
// conv_result_writer_if
// Bundles the result-writer signals apart from clk/rst: the convolution
// output stream, the capture status, and the random-access readback port.
//   start_i     arm / re-arm capture of a new frame
//   valid_i     data_i beat valid (no backpressure)
//   data_i      signed convolution result, IN_WIDTH bits
//   busy_o      high while capturing
//   done_o      one-cycle pulse after the last beat of a frame is stored
//   drop_o      sticky flag: a beat arrived while not capturing
//   wr_row_o    row index of the next write
//   wr_col_o    column index of the next write
//   rd_en_i     read request
//   rd_addr_i   linear read address (row*OUT_DIM+col)
//   rd_data_o   registered read data
//   rd_valid_o  rd_data_o valid, one cycle after rd_en_i
// Modport slave is the writer itself; modport master is the driving side
// (convolution core plus host/downstream reader).
// ----------------------------------------------------------------------------
interface conv_result_writer_if #(
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14
) ();
    logic                  start_i;
    logic                  valid_i;
    logic [IN_WIDTH-1:0]   data_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  drop_o;
    logic [ADDR_WIDTH-1:0] wr_row_o;
    logic [ADDR_WIDTH-1:0] wr_col_o;
    logic                  rd_en_i;
    logic [ADDR_WIDTH-1:0] rd_addr_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  rd_valid_o;

    modport slave (
        input  start_i, valid_i, data_i, rd_en_i, rd_addr_i,
        output busy_o, done_o, drop_o, wr_row_o, wr_col_o, rd_data_o, rd_valid_o
    );

    modport master (
        output start_i, valid_i, data_i, rd_en_i, rd_addr_i,
        input  busy_o, done_o, drop_o, wr_row_o, wr_col_o, rd_data_o, rd_valid_o
    );
endinterface

// File: rtl/conv_result_writer.sv
// ----------------------------------------------------------------------------
// conv_result_writer
// Sink end of the convolution output stream. Each valid beat is arithmetically
// shifted right by SHIFT, saturated to DATA_WIDTH signed bits and stored in an
// OUT_DIM x OUT_DIM result memory (OUT_DIM = N-K_SIZE+1) in raster order.
// A registered, read-first readback port serves the memory in any state.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (memory contents are kept)
//   bus   conv_result_writer_if.slave: stream in, status out, readback port
// ----------------------------------------------------------------------------
module conv_result_writer #(
    parameter int N          = 4,
    parameter int K_SIZE     = 3,
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 16,
    parameter int SHIFT      = 0,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                clk,
    input  logic                rst,
    conv_result_writer_if.slave bus
);
    localparam int OUT_DIM = N - K_SIZE + 1;
    localparam int OUT_PIX = OUT_DIM * OUT_DIM;
    localparam int MEM_AW  = (OUT_PIX > 1) ? $clog2(OUT_PIX) : 1;
    // One guard bit above the wider of input/output keeps the saturation
    // comparison exact in both directions.
    localparam int CW      = ((IN_WIDTH > DATA_WIDTH) ? IN_WIDTH : DATA_WIDTH) + 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(OUT_PIX - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(OUT_DIM - 1);
    // One bit wider than the address so OUT_PIX == 2**ADDR_WIDTH still compares.
    localparam logic [ADDR_WIDTH:0]   PIX_CNT   = (ADDR_WIDTH + 1)'(OUT_PIX);

    localparam logic signed [CW-1:0] SAT_MAX =
        {{(CW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN =
        {{(CW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Sign-extend, shift arithmetically, then clamp to the signed output range.
    function automatic logic [DATA_WIDTH-1:0] sat_scale(input logic [IN_WIDTH-1:0] din);
        logic signed [CW-1:0] t_ext;
        logic signed [CW-1:0] t_sh;
        t_ext = {{(CW - IN_WIDTH){din[IN_WIDTH-1]}}, din};
        t_sh  = t_ext >>> SHIFT;
        if (t_sh > SAT_MAX) begin
            sat_scale = SAT_MAX[DATA_WIDTH-1:0];
        end else if (t_sh < SAT_MIN) begin
            sat_scale = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_scale = t_sh[DATA_WIDTH-1:0];
        end
    endfunction

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_row_q,  wr_row_d;
    logic [ADDR_WIDTH-1:0] wr_col_q,  wr_col_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  drop_q,    drop_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    logic [DATA_WIDTH-1:0] mem_q [0:OUT_PIX-1];
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Pointer origin for this cycle: a start_i during capture restarts at 0.
    logic [ADDR_WIDTH-1:0] base_ptr;
    logic [ADDR_WIDTH-1:0] base_row;
    logic [ADDR_WIDTH-1:0] base_col;

    // Next-state, pointer, status and readback logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        done_d     = 1'b0;
        drop_d     = drop_q;
        mem_we     = 1'b0;
        mem_waddr  = {MEM_AW{1'b0}};
        mem_wdata  = sat_scale(bus.data_i);
        base_ptr   = wr_ptr_q;
        base_row   = wr_row_q;
        base_col   = wr_col_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) begin
                    state_d  = ST_CAPTURE;
                    wr_ptr_d = ADDR_ZERO;
                    wr_row_d = ADDR_ZERO;
                    wr_col_d = ADDR_ZERO;
                    drop_d   = 1'b0;
                end else if (bus.valid_i) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_CAPTURE: begin
                if (bus.start_i) begin
                    base_ptr = ADDR_ZERO;
                    base_row = ADDR_ZERO;
                    base_col = ADDR_ZERO;
                    drop_d   = 1'b0;
                end else begin
                    base_ptr = wr_ptr_q;
                    base_row = wr_row_q;
                    base_col = wr_col_q;
                end
                if (bus.valid_i) begin
                    mem_we    = ~rst;
                    mem_waddr = base_ptr[MEM_AW-1:0];
                    if (base_ptr == LAST_PTR) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        wr_ptr_d = ADDR_ZERO;
                        wr_row_d = ADDR_ZERO;
                        wr_col_d = ADDR_ZERO;
                    end else if (base_col == LAST_COL) begin
                        wr_ptr_d = base_ptr + ADDR_ONE;
                        wr_row_d = base_row + ADDR_ONE;
                        wr_col_d = ADDR_ZERO;
                    end else begin
                        wr_ptr_d = base_ptr + ADDR_ONE;
                        wr_row_d = base_row;
                        wr_col_d = base_col + ADDR_ONE;
                    end
                end else begin
                    wr_ptr_d = base_ptr;
                    wr_row_d = base_row;
                    wr_col_d = base_col;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wr_ptr_d = ADDR_ZERO;
                wr_row_d = ADDR_ZERO;
                wr_col_d = ADDR_ZERO;
            end
        endcase

        busy_d = (state_d == ST_CAPTURE);

        // Memory is sampled before this cycle's write lands: read-first.
        rd_valid_d = bus.rd_en_i;
        if (bus.rd_en_i) begin
            if ({1'b0, bus.rd_addr_i} < PIX_CNT) begin
                rd_data_d = mem_q[bus.rd_addr_i[MEM_AW-1:0]];
            end else begin
                rd_data_d = {DATA_WIDTH{1'b0}};
            end
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State, pointer, status and readback registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= ADDR_ZERO;
            wr_row_q   <= ADDR_ZERO;
            wr_col_q   <= ADDR_ZERO;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            rd_data_q  <= {DATA_WIDTH{1'b0}};
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Result memory write port; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.drop_o     = drop_q;
    assign bus.wr_row_o   = wr_row_q;
    assign bus.wr_col_o   = wr_col_q;
    assign bus.rd_data_o  = rd_data_q;
    assign bus.rd_valid_o = rd_valid_q;
endmodule

// File: tb/tb_conv_result_writer.sv
module tb_conv_result_writer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   done_base;

    always #5 clk = ~clk;

    conv_result_writer_if #(.IN_WIDTH(16), .DATA_WIDTH(16), .ADDR_WIDTH(14)) bus0 ();
    conv_result_writer_if #(.IN_WIDTH(24), .DATA_WIDTH(16), .ADDR_WIDTH(14)) bus1 ();

    conv_result_writer #(
        .N(4), .K_SIZE(3), .IN_WIDTH(16), .DATA_WIDTH(16), .SHIFT(0), .ADDR_WIDTH(14)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    conv_result_writer #(
        .N(4), .K_SIZE(3), .IN_WIDTH(24), .DATA_WIDTH(16), .SHIFT(4), .ADDR_WIDTH(14)
    ) u_dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus0.done_o) done_cnt++;
    endtask

    task automatic start_pulse();
        bus0.start_i = 1'b1;
        step();
        bus0.start_i = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        bus0.valid_i = 1'b1;
        bus0.data_i  = d;
        step();
        bus0.valid_i = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input int addr, input logic [15:0] exp);
        bus0.rd_en_i   = 1'b1;
        bus0.rd_addr_i = 14'(addr);
        step();
        bus0.rd_en_i   = 1'b0;
        check_eq({tag, "_vld"}, 32'(bus0.rd_valid_o), 32'd1);
        check_eq(tag, 32'(bus0.rd_data_o), 32'(exp));
    endtask

    logic [15:0] frame_a [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
    logic [15:0] frame_g [4] = '{16'd11, 16'd22, 16'd33, 16'd44};
    int          row_exp [4] = '{0, 1, 1, 0};
    int          col_exp [4] = '{1, 0, 1, 0};
    logic [23:0] sat_in  [4] = '{24'h100000, 24'hF00000, 24'h000123, 24'hFFFFF0};
    logic [15:0] sat_exp [4] = '{16'h7FFF, 16'h8000, 16'h0012, 16'hFFFF};

    initial begin
        int g;
        rst = 1'b1;
        bus0.start_i = 1'b0; bus0.valid_i = 1'b0; bus0.data_i = 16'd0;
        bus0.rd_en_i = 1'b0; bus0.rd_addr_i = 14'd0;
        bus1.start_i = 1'b0; bus1.valid_i = 1'b0; bus1.data_i = 24'd0;
        bus1.rd_en_i = 1'b0; bus1.rd_addr_i = 14'd0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check_eq("rst_busy", 32'(bus0.busy_o), 32'd0);
        check_eq("rst_done", 32'(bus0.done_o), 32'd0);
        check_eq("rst_drop", 32'(bus0.drop_o), 32'd0);
        check_eq("rst_row", 32'(bus0.wr_row_o), 32'd0);
        check_eq("rst_col", 32'(bus0.wr_col_o), 32'd0);
        check_eq("rst_rvld", 32'(bus0.rd_valid_o), 32'd0);
        check_eq("rst_rdata", 32'(bus0.rd_data_o), 32'd0);

        // Back-to-back frame 10,20,30,40 with row/col tracking
        start_pulse();
        check_eq("a_busy", 32'(bus0.busy_o), 32'd1);
        check_eq("a_row0", 32'(bus0.wr_row_o), 32'd0);
        check_eq("a_col0", 32'(bus0.wr_col_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            beat(frame_a[i]);
            check_eq($sformatf("a_row%0d", i + 1), 32'(bus0.wr_row_o), 32'(row_exp[i]));
            check_eq($sformatf("a_col%0d", i + 1), 32'(bus0.wr_col_o), 32'(col_exp[i]));
            check_eq($sformatf("a_done%0d", i + 1), 32'(bus0.done_o), (i == 3) ? 32'd1 : 32'd0);
        end
        check_eq("a_busy_end", 32'(bus0.busy_o), 32'd0);
        step();
        check_eq("a_done_clr", 32'(bus0.done_o), 32'd0);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("a_rd%0d", i), i, frame_a[i]);
        step();
        check_eq("a_rvld_off", 32'(bus0.rd_valid_o), 32'd0);
        check_eq("a_rdata_hold", 32'(bus0.rd_data_o), 32'd40);

        // Gapped beats at cycles 0,3,4,9
        start_pulse();
        g = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 3 || c == 4 || c == 9) begin
                bus0.valid_i = 1'b1;
                bus0.data_i  = frame_g[g];
                g++;
            end else begin
                bus0.valid_i = 1'b0;
            end
            step();
            bus0.valid_i = 1'b0;
            check_eq($sformatf("g_busy_c%0d", c), 32'(bus0.busy_o), (c == 9) ? 32'd0 : 32'd1);
            check_eq($sformatf("g_done_c%0d", c), 32'(bus0.done_o), (c == 9) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) rd_chk($sformatf("g_rd%0d", i), i, frame_g[i]);

        // Beat in DONE is dropped; sticky until the next start
        beat(16'd99);
        check_eq("drop_set", 32'(bus0.drop_o), 32'd1);
        step();
        check_eq("drop_hold", 32'(bus0.drop_o), 32'd1);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("drop_rd%0d", i), i, frame_g[i]);
        start_pulse();
        check_eq("drop_clr", 32'(bus0.drop_o), 32'd0);
        for (int i = 0; i < 4; i++) beat(16'(i + 1));
        rd_chk("ovr_rd0", 0, 16'd1);
        rd_chk("ovr_rd3", 3, 16'd4);

        // Abort: restart after two beats, beat 5 lands with the restart
        start_pulse();
        beat(16'd100);
        beat(16'd101);
        check_eq("ab_row2", 32'(bus0.wr_row_o), 32'd1);
        check_eq("ab_col2", 32'(bus0.wr_col_o), 32'd0);
        done_base = done_cnt;
        bus0.start_i = 1'b1;
        bus0.valid_i = 1'b1;
        bus0.data_i  = 16'd5;
        step();
        bus0.start_i = 1'b0;
        bus0.valid_i = 1'b0;
        check_eq("ab_row_re", 32'(bus0.wr_row_o), 32'd0);
        check_eq("ab_col_re", 32'(bus0.wr_col_o), 32'd1);
        check_eq("ab_busy_re", 32'(bus0.busy_o), 32'd1);
        beat(16'd6);
        beat(16'd7);
        beat(16'd8);
        step();
        step();
        check_eq("ab_done_cnt", 32'(done_cnt - done_base), 32'd1);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("ab_rd%0d", i), i, 16'(i + 5));

        // Reset mid-capture keeps the partial frame
        start_pulse();
        beat(16'd50);
        beat(16'd51);
        done_base = done_cnt;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("mr_busy", 32'(bus0.busy_o), 32'd0);
        check_eq("mr_done", 32'(bus0.done_o), 32'd0);
        check_eq("mr_row", 32'(bus0.wr_row_o), 32'd0);
        check_eq("mr_col", 32'(bus0.wr_col_o), 32'd0);
        step();
        check_eq("mr_done_cnt", 32'(done_cnt - done_base), 32'd0);
        rd_chk("mr_rd0", 0, 16'd50);
        rd_chk("mr_rd1", 1, 16'd51);
        rd_chk("mr_rd2", 2, 16'd7);
        rd_chk("mr_rd3", 3, 16'd8);

        // Out-of-range reads
        rd_chk("oor_rd4", 4, 16'd0);
        rd_chk("oor_rd100", 100, 16'd0);

        // Same-cycle read and write of address 1 returns the old word
        start_pulse();
        beat(16'd60);
        bus0.valid_i   = 1'b1;
        bus0.data_i    = 16'd61;
        bus0.rd_en_i   = 1'b1;
        bus0.rd_addr_i = 14'd1;
        step();
        bus0.valid_i = 1'b0;
        bus0.rd_en_i = 1'b0;
        check_eq("rf_vld", 32'(bus0.rd_valid_o), 32'd1);
        check_eq("rf_old", 32'(bus0.rd_data_o), 32'd51);
        rd_chk("rf_new", 1, 16'd61);
        rd_chk("rf_a0", 0, 16'd60);

        // Shift-by-4 and saturation on the 24-bit instance
        bus1.start_i = 1'b1;
        step();
        bus1.start_i = 1'b0;
        check_eq("sat_busy", 32'(bus1.busy_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus1.valid_i = 1'b1;
            bus1.data_i  = sat_in[i];
            step();
            bus1.valid_i = 1'b0;
            check_eq($sformatf("sat_done%0d", i), 32'(bus1.done_o), (i == 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            bus1.rd_en_i   = 1'b1;
            bus1.rd_addr_i = 14'(i);
            step();
            bus1.rd_en_i   = 1'b0;
            check_eq($sformatf("sat_vld%0d", i), 32'(bus1.rd_valid_o), 32'd1);
            check_eq($sformatf("sat_rd%0d", i), 32'(bus1.rd_data_o), 32'(sat_exp[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
